// File: rtl/mux_arb_reg_pkg.sv
// Shared definitions for the registered N-channel multiplexer/arbiter.
package mux_arb_reg_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage

// File: rtl/mux_arb_reg_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last+1 with wrap.
module rr_arbiter
  import mux_arb_reg_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] gnt,
  output logic             gnt_vld
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(last) + k) % N_CH;
      if (!gnt_vld && req[idx]) begin
        gnt     = SEL_W'(idx);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb_reg.sv
// Registered N-channel valid/ready multiplexer with fixed-select or round-robin grant
// feeding a one-entry output register that sustains one word per cycle.
module mux_arb_reg
  import mux_arb_reg_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch
);

  logic             load;
  logic             xfer;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] rr_gnt;
  logic             rr_vld;
  logic [SEL_W-1:0] gnt;
  logic             gnt_vld;

  assign load = !out_valid || out_ready;

  rr_arbiter #(.N_CH(N_CH)) u_rr_arbiter (
    .req     (in_valid),
    .last    (last),
    .gnt     (rr_gnt),
    .gnt_vld (rr_vld)
  );

  always_comb begin
    gnt     = sel;
    gnt_vld = 1'b0;
    if (mode == MODE_RR) begin
      gnt     = rr_gnt;
      gnt_vld = rr_vld;
    end else if (int'(sel) < N_CH) begin
      gnt_vld = in_valid[sel];
    end
  end

  assign xfer = load && gnt_vld;

  // Gated by rst_n so no producer sees a handshake while reset is held.
  always_comb begin
    in_ready = '0;
    if (rst_n && xfer) begin
      in_ready[gnt] = 1'b1;
    end
  end

  // Output register stage; last is only advanced by round-robin transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last      <= SEL_W'(N_CH - 1);
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[gnt*WIDTH +: WIDTH];
        out_ch    <= gnt;
        if (mode == MODE_RR) begin
          last <= gnt;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed bench for mux_arb_reg with a scoreboard of expected output words.
module tb_mux_arb_reg;
  import mux_arb_reg_pkg::*;

  localparam int WIDTH = 8;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic [N_CH*WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_ch;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [9:0] sb[$];
  logic [9:0] exp_word;
  logic [7:0] held_data;
  int         seq4[4] = '{1, 3, 1, 3};

  always #5 clk = ~clk;

  mux_arb_reg #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_data();
    for (int i = 0; i < N_CH; i++) in_data[i*WIDTH +: WIDTH] = 8'(i*16 + (cyc & 15));
    cyc++;
  endtask

  task automatic push(input int ch);
    sb.push_back({2'(ch), in_data[ch*WIDTH +: WIDTH]});
  endtask

  // Every word the consumer accepts must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL sb_underflow observed=ch%0d/%0h expected=queued_word", out_ch, out_data);
      end
      if (sb.size() != 0) begin
        exp_word = sb.pop_front();
        chk("sb_ch", 32'(out_ch), 32'(exp_word[9:8]));
        chk("sb_data", 32'(out_data), 32'(exp_word[7:0]));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    mode      = MODE_FIXED;
    sel       = '0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    load_data();
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ch", 32'(out_ch), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    step();
    step();
    chk("rst_hold_valid", 32'(out_valid), 0);
    chk("rst_hold_ready", 32'(in_ready), 0);
    rst_n    = 1'b1;
    in_valid = '0;
    step();

    // Fixed select of channel 2 with every channel requesting.
    mode     = MODE_FIXED;
    sel      = 2'd2;
    in_valid = 4'hF;
    load_data();
    in_data[2*WIDTH +: WIDTH] = 8'hA5;
    #1;
    chk("fix_in_ready", 32'(in_ready), 32'h4);
    push(2);
    step();
    in_valid = '0;
    #1;
    chk("fix_out_valid", 32'(out_valid), 1);
    chk("fix_out_data", 32'(out_data), 32'hA5);
    chk("fix_out_ch", 32'(out_ch), 2);
    step();
    chk("fix_drain_valid", 32'(out_valid), 0);

    // Round robin, all channels requesting.
    mode     = MODE_RR;
    in_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      load_data();
      #1;
      chk("rr_in_ready", 32'(in_ready), 32'(1 << (c % 4)));
      push(c % 4);
      step();
    end
    in_valid = '0;
    step();

    // Round robin with only channels 1 and 3 requesting.
    in_valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      load_data();
      #1;
      chk("rr_sparse_ready", 32'(in_ready), 32'(1 << seq4[c]));
      push(seq4[c]);
      step();
    end
    in_valid = '0;
    step();

    // Backpressure: word from ch0 held while inputs toggle.
    in_valid = 4'hF;
    load_data();
    held_data = in_data[7:0];
    push(0);
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 4'($urandom);
      load_data();
      #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_ch", 32'(out_ch), 0);
      chk("bp_out_data", 32'(out_data), 32'(held_data));
      step();
    end
    in_valid  = 4'hF;
    out_ready = 1'b1;
    load_data();
    #1;
    chk("bp_resume_ready", 32'(in_ready), 32'h2);
    push(1);
    step();
    in_valid = '0;
    step();
    chk("bp_sb_empty", 32'(sb.size()), 0);

    // Fixed select of an idle channel grants nothing.
    mode     = MODE_FIXED;
    sel      = 2'd2;
    in_valid = 4'b0001;
    #1;
    chk("fix_idle_ready", 32'(in_ready), 0);
    // Fixed transfer must not disturb the round-robin pointer (last = 1).
    sel      = 2'd3;
    in_valid = 4'hF;
    load_data();
    #1;
    chk("fix3_in_ready", 32'(in_ready), 32'h8);
    push(3);
    step();
    mode = MODE_RR;
    load_data();
    #1;
    chk("rr_retained_ready", 32'(in_ready), 32'h4);
    push(2);
    step();

    // Mid-stream async reset.
    load_data();
    #1;
    chk("pre_rst_ready", 32'(in_ready), 32'h8);
    push(3);
    step();
    load_data();
    #1;
    chk("pre_rst_ready2", 32'(in_ready), 32'h1);
    push(0);
    step();
    load_data();
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_data", 32'(out_data), 0);
    chk("arst_out_ch", 32'(out_ch), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    step();
    rst_n = 1'b1;
    load_data();
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'h1);
    push(0);
    step();
    in_valid = '0;
    step();

    for (int w = 0; w < 20 && sb.size() != 0; w++) step();
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
